// File: rtl/npc_pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
// Holds the next-PC select codes and the field widths used by fetch/control.
package npc_pc_unit_pkg;

  localparam int unsigned NPC_OP_W = 3;
  localparam int unsigned IMM_W    = 26;
  localparam int unsigned BR_IMM_W = 16;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_REG    = 3'b011,
    NPC_RET    = 3'b100,
    NPC_ERET   = 3'b101
  } npc_op_e;

  // True when a register-supplied target is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/npc_ras_stack.sv
// Circular return-address stack with a saturating entry count.
// A full stack overwrites its oldest entry; push+pop together replaces the top.
module npc_ras_stack
  import npc_pc_unit_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned WIDTH     = 32,
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic             do_pop;
  logic             full;

  assign do_pop = pop && (cnt_q != '0);
  assign full   = (cnt_q == CNT_W'(RAS_DEPTH));

  // Pointer/count update; a pop on an empty stack is ignored.
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = top_q;
    if (push && do_pop) begin
      wr_en  = 1'b1;
      wr_ptr = top_q;
    end else if (push) begin
      wr_en  = 1'b1;
      top_d  = top_q + PTR_W'(1);
      wr_ptr = top_q + PTR_W'(1);
      cnt_d  = full ? cnt_q : cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  assign top   = mem[top_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/npc_pc_unit.sv
// Program-counter unit: PC/EPC registers, next-PC selection, return-address stack.
// Priority on each edge is reset, then exception, then stall, then npc_op.
module npc_pc_unit
  import npc_pc_unit_pkg::*;
#(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic [IMM_W-1:0]    imm,
  input  logic [WIDTH-1:0]    rd1,
  input  logic                link,
  input  logic                exc_req,
  output logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    pc_plus4,
  output logic [WIDTH-1:0]    epc,
  output logic                ras_empty,
  output logic                ras_uflow,
  output logic                misalign
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             uflow_q, uflow_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] reg_tgt;
  logic [WIDTH-1:0] ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty_w;
  logic             advance;
  logic             ras_push;
  logic             ras_pop;
  npc_op_e          op;

  assign op       = npc_op_e'(npc_op);
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_off   = {{(WIDTH-BR_IMM_W-2){imm[BR_IMM_W-1]}}, imm[BR_IMM_W-1:0], 2'b00};
  assign jump_tgt = {pc_plus4[WIDTH-1:28], imm, 2'b00};
  assign reg_tgt  = {rd1[WIDTH-1:2], 2'b00};

  // Stack traffic only moves on a cycle that actually retires a next-PC.
  assign advance  = !stall && !exc_req;
  assign ras_push = advance && link;
  assign ras_pop  = advance && (op == NPC_RET) && (ras_count != '0);

  npc_ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .WIDTH     (WIDTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty_w),
    .count (ras_count)
  );

  // Next-PC selection and status pulses.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    uflow_d = 1'b0;
    mis_d   = 1'b0;
    if (exc_req) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (!stall) begin
      case (op)
        NPC_BRANCH: pc_d = pc_plus4 + br_off;
        NPC_JUMP:   pc_d = jump_tgt;
        NPC_REG: begin
          pc_d  = reg_tgt;
          mis_d = is_misaligned(rd1[1:0]);
        end
        NPC_RET: begin
          if (!ras_empty_w) begin
            pc_d = ras_top;
          end else begin
            pc_d    = reg_tgt;
            uflow_d = 1'b1;
            mis_d   = is_misaligned(rd1[1:0]);
          end
        end
        NPC_ERET:   pc_d = epc_q;
        default:    pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      uflow_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      uflow_q <= uflow_d;
      mis_q   <= mis_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign ras_empty = ras_empty_w;
  assign ras_uflow = uflow_q;
  assign misalign  = mis_q;

endmodule
